// File: rtl/word_mem_seq.sv
// word_mem_seq: WIDTH x DEPTH word memory addressed by a sequential pointer.
// Supports store-and-advance, next/prev browsing, direct jump, wrap or
// saturate at the ends, a one-cycle boundary pulse and a clear-all engine.
module word_mem_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH),
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             store,
  input  logic             next,
  input  logic             prev,
  input  logic             jump,
  input  logic [AW-1:0]    jaddr,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic [AW-1:0]    addr,
  output logic             busy,
  output logic             bound
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [AW-1:0] P_LAST  = AW'(DEPTH - 1);
  localparam logic [AW:0]   P_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  state_t           r_state;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_cptr;
  logic             r_bound;

  state_t           w_state_nxt;
  logic [AW-1:0]    w_addr_nxt;
  logic [AW-1:0]    w_cptr_nxt;
  logic             w_bound_nxt;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic             w_at_last;
  logic             w_at_first;
  logic [AW-1:0]    w_addr_inc;
  logic [AW-1:0]    w_addr_dec;
  logic             w_jump_ok;

  // Pointer moves use explicit end compares so non-power-of-two DEPTH works.
  assign w_at_last  = (r_addr == P_LAST);
  assign w_at_first = (r_addr == '0);
  assign w_addr_inc = w_at_last  ? ((WRAP != 0) ? '0     : r_addr) : r_addr + AW'(1);
  assign w_addr_dec = w_at_first ? ((WRAP != 0) ? P_LAST : r_addr) : r_addr - AW'(1);
  assign w_jump_ok  = ({1'b0, jaddr} < P_DEPTH);

  // Next-state, pointer and write-port control; commands only act in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cptr_nxt  = r_cptr;
    w_bound_nxt = 1'b0;
    w_we        = 1'b0;
    w_waddr     = r_addr;
    w_wdata     = din;
    unique case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_state_nxt = S_CLEAR;
          w_cptr_nxt  = '0;
        end else if (jump) begin
          if (w_jump_ok) w_addr_nxt  = jaddr;
          else           w_bound_nxt = 1'b1;
        end else if (store) begin
          w_we        = 1'b1;
          w_addr_nxt  = w_addr_inc;
          w_bound_nxt = w_at_last;
        end else if (next) begin
          w_addr_nxt  = w_addr_inc;
          w_bound_nxt = w_at_last;
        end else if (prev) begin
          w_addr_nxt  = w_addr_dec;
          w_bound_nxt = w_at_first;
        end
      end
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_cptr;
        w_wdata = '0;
        if (r_cptr == P_LAST) begin
          w_state_nxt = S_IDLE;
          w_addr_nxt  = '0;
        end else begin
          w_cptr_nxt = r_cptr + AW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cptr  <= '0;
      r_bound <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cptr  <= w_cptr_nxt;
      r_bound <= w_bound_nxt;
    end
  end

  // Memory array is never reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (rst_n && w_we) r_mem[w_waddr] <= w_wdata;
  end

  assign dout  = r_mem[r_addr];
  assign addr  = r_addr;
  assign busy  = (r_state == S_CLEAR);
  assign bound = r_bound;

endmodule

// File: tb/tb_word_mem_seq.sv
// tb_word_mem_seq: three word_mem_seq instances (default, 8x10 wrap,
// 8x10 saturate) share one command stream and are checked every cycle
// against an array-based reference model, plus directed sequences.
module tb_word_mem_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, store, next, prev, jump, clear;
  logic [7:0] din;
  logic [5:0] jaddr;

  logic [3:0] a_dout;
  logic [5:0] a_addr;
  logic       a_busy, a_bound;
  logic [7:0] b_dout, c_dout;
  logic [3:0] b_addr, c_addr;
  logic       b_busy, b_bound, c_busy, c_bound;

  word_mem_seq u_a (
    .clk(clk), .rst_n(rst_n), .din(din[3:0]), .store(store), .next(next),
    .prev(prev), .jump(jump), .jaddr(jaddr), .clear(clear),
    .dout(a_dout), .addr(a_addr), .busy(a_busy), .bound(a_bound));

  word_mem_seq #(.WIDTH(8), .DEPTH(10), .WRAP(1)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din), .store(store), .next(next),
    .prev(prev), .jump(jump), .jaddr(jaddr[3:0]), .clear(clear),
    .dout(b_dout), .addr(b_addr), .busy(b_busy), .bound(b_bound));

  word_mem_seq #(.WIDTH(8), .DEPTH(10), .WRAP(0)) u_c (
    .clk(clk), .rst_n(rst_n), .din(din), .store(store), .next(next),
    .prev(prev), .jump(jump), .jaddr(jaddr[3:0]), .clear(clear),
    .dout(c_dout), .addr(c_addr), .busy(c_busy), .bound(c_bound));

  int PW [3] = '{4, 8, 8};
  int PD [3] = '{64, 10, 10};
  int PWR[3] = '{1, 1, 0};
  int PAW[3] = '{6, 4, 4};

  int m_mem [3][64];
  int m_addr [3];
  int m_left [3];
  int m_bound[3];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void mmove(int k, int dir);
    int t = m_addr[k] + dir;
    if (t < 0 || t >= PD[k]) begin
      m_bound[k] = 1;
      t = (PWR[k] != 0) ? (t + PD[k]) % PD[k] : m_addr[k];
    end
    m_addr[k] = t;
  endfunction

  function automatic void mstep(int k);
    int d  = PD[k];
    int ja = int'(jaddr) % (1 << PAW[k]);
    int dv = int'(din) % (1 << PW[k]);
    m_bound[k] = 0;
    if (!rst_n) begin
      m_addr[k] = 0;
      m_left[k] = 0;
    end else if (m_left[k] > 0) begin
      m_mem[k][d - m_left[k]] = 0;
      m_left[k]--;
      if (m_left[k] == 0) m_addr[k] = 0;
    end else if (clear) begin
      m_left[k] = d;
    end else if (jump) begin
      if (ja < d) m_addr[k] = ja;
      else        m_bound[k] = 1;
    end else if (store) begin
      m_mem[k][m_addr[k]] = dv;
      mmove(k, 1);
    end else if (next) begin
      mmove(k, 1);
    end else if (prev) begin
      mmove(k, -1);
    end
  endfunction

  function automatic int act(int k, int which);
    case (which)
      0: return (k == 0) ? int'(a_addr)  : (k == 1) ? int'(b_addr)  : int'(c_addr);
      1: return (k == 0) ? int'(a_dout)  : (k == 1) ? int'(b_dout)  : int'(c_dout);
      2: return (k == 0) ? int'(a_busy)  : (k == 1) ? int'(b_busy)  : int'(c_busy);
      default: return (k == 0) ? int'(a_bound) : (k == 1) ? int'(b_bound) : int'(c_bound);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 3; k++) mstep(k);
    #1;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_addr[%0d]", k),  act(k, 0), m_addr[k]);
        chk($sformatf("model_dout[%0d]", k),  act(k, 1), m_mem[k][m_addr[k]]);
        chk($sformatf("model_busy[%0d]", k),  act(k, 2), int'(m_left[k] > 0));
        chk($sformatf("model_bound[%0d]", k), act(k, 3), m_bound[k]);
      end
    end
  endtask

  task automatic cmd(bit jp, bit st, bit nx, bit pv, bit cl, int dv, int ja);
    jump = jp; store = st; next = nx; prev = pv; clear = cl;
    din = 8'(dv); jaddr = 6'(ja);
    step();
    jump = 0; store = 0; next = 0; prev = 0; clear = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (a_busy || b_busy || c_busy); i++) step();
    chk("wait_idle", int'(a_busy | b_busy | c_busy), 0);
  endtask

  typedef struct {
    bit jp, st, nx, pv;
    int dv, ja;
    int ba, bb, bd;
    int ca, cb, cd;
  } vec_t;

  vec_t tv[9];
  int   cnt;

  initial begin
    // B/C contents when the table runs: [0]=0x0A, [1]=0x0F, others 0
    tv[0] = '{1, 0, 0, 0, 'h00, 9,  9, 0, 'h00,  9, 0, 'h00};
    tv[1] = '{0, 1, 0, 0, 'h5A, 0,  0, 1, 'h0A,  9, 1, 'h5A};
    tv[2] = '{0, 0, 0, 1, 'h00, 0,  9, 1, 'h5A,  8, 0, 'h00};
    tv[3] = '{1, 0, 0, 0, 'h00, 9,  9, 0, 'h5A,  9, 0, 'h5A};
    tv[4] = '{0, 0, 1, 0, 'h00, 0,  0, 1, 'h0A,  9, 1, 'h5A};
    tv[5] = '{1, 0, 0, 0, 'h00, 0,  0, 0, 'h0A,  0, 0, 'h0A};
    tv[6] = '{0, 0, 0, 1, 'h00, 0,  9, 1, 'h5A,  0, 1, 'h0A};
    tv[7] = '{1, 0, 0, 0, 'h00, 12, 9, 1, 'h5A,  0, 1, 'h0A};
    tv[8] = '{0, 0, 0, 0, 'h00, 0,  9, 0, 'h5A,  0, 0, 'h0A};

    rst_n = 0; store = 0; next = 0; prev = 0; jump = 0; clear = 0;
    din = '0; jaddr = '0;
    for (int k = 0; k < 3; k++) begin
      m_addr[k] = 0; m_left[k] = 0; m_bound[k] = 0;
      for (int i = 0; i < 64; i++) m_mem[k][i] = 0;
    end

    // Bring all memories to a known all-zero state.
    step(); step();
    rst_n = 1;
    cmd(0, 0, 0, 0, 1, 0, 0);
    wait_idle();
    chk_en = 1'b1;

    // Reset and basic store/browse sequence on the default instance.
    rst_n = 0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_addr", int'(a_addr), 0);
    chk("rst_busy", int'(a_busy), 0);
    chk("rst_bound", int'(a_bound), 0);
    rst_n = 1;
    cmd(0, 1, 0, 0, 0, 'hA, 0); chk("t1_addr0", int'(a_addr), 1);
    cmd(0, 1, 0, 0, 0, 'h3, 0); chk("t1_addr1", int'(a_addr), 2);
    cmd(0, 0, 0, 1, 0, 0, 0);   chk("t1_addr2", int'(a_addr), 1);
    cmd(0, 0, 0, 1, 0, 0, 0);   chk("t1_addr3", int'(a_addr), 0);
    cmd(0, 0, 1, 0, 0, 0, 0);   chk("t1_addr4", int'(a_addr), 1);
    cmd(0, 1, 0, 0, 0, 'hF, 0); chk("t1_addr5", int'(a_addr), 2);
    cmd(1, 0, 0, 0, 0, 0, 1);   chk("t1_mem1", int'(a_dout), 'hF);
    cmd(1, 0, 0, 0, 0, 0, 0);   chk("t1_mem0", int'(a_dout), 'hA);

    // Wrap / saturate / out-of-range jump table for the 8x10 instances.
    foreach (tv[i]) begin
      cmd(tv[i].jp, tv[i].st, tv[i].nx, tv[i].pv, 0, tv[i].dv, tv[i].ja);
      chk($sformatf("tv%0d_b_addr", i),  int'(b_addr),  tv[i].ba);
      chk($sformatf("tv%0d_b_bound", i), int'(b_bound), tv[i].bb);
      chk($sformatf("tv%0d_b_dout", i),  int'(b_dout),  tv[i].bd);
      chk($sformatf("tv%0d_c_addr", i),  int'(c_addr),  tv[i].ca);
      chk($sformatf("tv%0d_c_bound", i), int'(c_bound), tv[i].cb);
      chk($sformatf("tv%0d_c_dout", i),  int'(c_dout),  tv[i].cd);
    end

    // Fill with 0xFF, clear from addr 4, commands during busy ignored.
    cmd(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cmd(0, 1, 0, 0, 0, 'hFF, 0);
    cmd(1, 0, 0, 0, 0, 0, 4);
    cmd(0, 0, 0, 0, 1, 0, 0);
    cnt = 0;
    while (b_busy && cnt < 40) begin
      cnt++;
      if (cnt == 3) chk("t4_addr_hold", int'(b_addr), 4);
      cmd(0, 1, cnt[0], 0, 0, 'h11, 0);
    end
    chk("t4_busy_len", cnt, 10);
    chk("t4_addr_exit", int'(b_addr), 0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_sweep%0d", i), int'(b_dout), 0);
      cmd(0, 0, 1, 0, 0, 0, 0);
    end
    wait_idle();

    // Priority cases.
    cmd(1, 0, 0, 0, 0, 0, 2);
    cmd(0, 1, 0, 0, 1, 'h33, 0);
    chk("t5_clr_busy", int'(b_busy), 1);
    chk("t5_clr_addr", int'(b_addr), 2);
    wait_idle();
    cmd(1, 1, 0, 0, 0, 'h07, 3);
    chk("t5_jmp_addr", int'(b_addr), 3);
    chk("t5_jmp_nowr", int'(b_dout), 0);
    cmd(0, 0, 1, 1, 0, 0, 0);
    chk("t5_np_addr", int'(b_addr), 4);

    // Reset in the 4th busy cycle aborts the clear before word 3.
    cmd(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cmd(0, 1, 0, 0, 0, 'hFF, 0);
    cmd(0, 0, 0, 0, 1, 0, 0);
    step(); step(); step();
    rst_n = 0;
    step();
    chk("t6_busy", int'(b_busy), 0);
    chk("t6_addr", int'(b_addr), 0);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      cmd(1, 0, 0, 0, 0, 0, i);
      chk($sformatf("t6_word%0d", i), int'(b_dout), (i < 3) ? 0 : 'hFF);
    end

    // Randomized command stream against the reference model.
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      jump  = ($urandom_range(0, 7) == 0);
      store = ($urandom_range(0, 3) == 0);
      next  = ($urandom_range(0, 3) == 0);
      prev  = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 59) == 0);
      din   = 8'($urandom);
      jaddr = 6'($urandom);
      step();
    end
    rst_n = 1; jump = 0; store = 0; next = 0; prev = 0; clear = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/word_mem_seq.md
Name: word_mem_seq

Overview:
- Parametrised successor to the 4x64 nibble store: a WIDTH x DEPTH word memory with a sequential address pointer.
- Store writes the current word and auto-increments the pointer; next/prev browse without writing.
- New over the nibble store: direct address load (jump), selectable wrap/saturate at the ends, a bound-violation pulse, and a multi-cycle clear-all engine with a busy flag.
- Sits behind a front-panel/debug controller that issues single-cycle command pulses.

Parameters:
- WIDTH, 4, data word width in bits (>=1).
- DEPTH, 64, number of words (>=2; need not be a power of two).
- AW, $clog2(DEPTH), address width; derived, do not override.
- WRAP, 1, 1 = pointer wraps at the ends; 0 = pointer saturates at 0 / DEPTH-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- din  in  WIDTH  write data, sampled on store.
- store  in  1  write din to mem[addr], then advance pointer.
- next  in  1  advance pointer by one.
- prev  in  1  retreat pointer by one.
- jump  in  1  load pointer from jaddr.
- jaddr  in  AW  jump target.
- clear  in  1  start zero-fill of the whole array.
- dout  out  WIDTH  combinational mem[addr].
- addr  out  AW  current pointer (registered).
- busy  out  1  high while the clear engine runs.
- bound  out  1  one-cycle pulse on a boundary event (see below).

Behaviour:
- Reset, on a clk edge with rst_n=0: addr=0, busy=0, bound=0, FSM=IDLE.
  - Memory contents are NOT reset.
  - Reset aborts an in-progress clear immediately; words not yet cleared keep their old values.
- dout = mem[addr] combinationally.
  - A store updates mem and addr on the same edge, so dout then shows the new addr's word.
- All commands are sampled on the rising edge in IDLE.
- Priority when several are high: clear > jump > store > next > prev. Only the highest-priority command acts.
- store: mem[addr] <= din; addr advances exactly as for next, including boundary handling.
- next at addr = DEPTH-1:
  - WRAP=1: addr -> 0, bound pulses.
  - WRAP=0: addr holds, bound pulses.
- prev at addr = 0:
  - WRAP=1: addr -> DEPTH-1, bound pulses.
  - WRAP=0: addr holds, bound pulses.
  - A store at DEPTH-1 always writes; only the pointer move is subject to wrap/saturate.
- jump: if jaddr < DEPTH, addr <= jaddr. Otherwise addr holds and bound pulses.
- bound is registered: high for exactly the cycle after the offending edge, and 0 in all other cycles.
- FSM states are IDLE and CLEAR.
  - IDLE --clear--> CLEAR: busy=1 from the next cycle; internal counter cptr=0.
  - In CLEAR, each cycle writes mem[cptr] <= 0 and increments cptr. After writing DEPTH-1 (DEPTH cycles total), go to IDLE with busy=0 and addr=0.
  - While busy, all inputs except rst_n are ignored; no bound pulses are generated.
  - addr holds its pre-clear value during CLEAR and goes to 0 on the exit edge.
  - A clear asserted in the same cycle as store: the clear wins and the store does not write.
- Widths: the pointer increments and decrements with explicit compare to DEPTH-1 and 0. It never relies on natural AW overflow, so DEPTH need not be a power of two.
- Write and read never conflict: there is a single write port and an asynchronous read at addr.

Test Plan:
1. Default params. Reset 3 cycles, then store din=0xA, store 0x3, prev, prev, next, store 0xF.
   - Required: addr sequence 1,2,1,0,1,2.
   - Final mem[0]=0xA, mem[1]=0xF; dout at addr 1 reads 0xF after jump to 1.
2. WIDTH=8, DEPTH=10, WRAP=1. jump jaddr=9, store 0x5A.
   - Required: mem[9]=0x5A, addr=0, bound high one cycle.
   - Then prev -> addr=9, bound pulses again.
3. WIDTH=8, DEPTH=10, WRAP=0. jump 9, then next.
   - Required: addr stays 9, bound pulses.
   - jump 0, then prev -> addr stays 0, bound pulses.
   - jump jaddr=12 -> addr unchanged, bound pulses.
4. DEPTH=10. Fill all words with 0xFF, set addr=4, pulse clear.
   - Required: busy=1 for exactly 10 cycles.
   - store/next pulses issued during busy have no effect.
   - Afterwards addr=0, busy=0, and every word reads 0x00 via a next sweep.
5. Priority:
   - clear+store in the same cycle -> no write, clear runs.
   - jump(3)+store(din=0x7) -> addr=3, no write.
   - next+prev -> addr+1.
6. Reset mid-clear: DEPTH=10, all 0xFF, pulse clear, assert rst_n=0 on the 4th busy cycle.
   - Required: next cycle busy=0, addr=0.
   - Words 0-2 read 0x00, words 4-9 read 0xFF.
   - Word 3 reads 0xFF: the reset edge takes priority, so no write occurs on it.
